// File: rtl/piso_tx_pkg.sv
// Shared types and width helpers for the piso_tx serial transmitter.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Bit counter must hold WIDTH itself after the final increment.
  function automatic int unsigned bitcnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned divcnt_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/piso_tx_baud.sv
// Bit-period divider for piso_tx: tick marks the last cycle of each DIV-cycle period.
module piso_tx_baud
  import piso_tx_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned     DCW  = divcnt_width(DIV);
  localparam logic [DCW-1:0]  LAST = DCW'(DIV - 1);

  logic [DCW-1:0] divcnt_q, divcnt_d;

  always_comb begin
    tick = run && (divcnt_q == LAST);
    if (!run || tick) begin
      divcnt_d = '0;
    end else begin
      divcnt_d = divcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      divcnt_q <= '0;
    end else begin
      divcnt_q <= divcnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word in, LSB-first on sout, one bit per DIV clocks.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the MSB.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             bit_stb,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    BCW      = bitcnt_width(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic             tick;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  piso_tx_baud #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .clear (clear),
    .run   (busy),
    .tick  (tick)
  );

  // Kept apart from the FSM block so busy -> tick -> next-state is not seen as a loop.
  always_comb begin
    busy      = (state_q != IDLE);
    din_ready = (state_q == IDLE) && !clear;
    bit_stb   = tick;
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    sout     = 1'b0;
    done     = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (din_valid && din_ready) begin
          sreg_d   = din;
          bitcnt_d = '0;
`ifdef PISO_TX_PARITY_EN
          par_d    = ^din;
`endif
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sout = sreg_q[0];
        if (tick) begin
          sreg_d   = {1'b0, sreg_q[WIDTH-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done    = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        sout = par_q;
        if (tick) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
`ifdef PISO_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: DIV=1 and DIV=3 instances share stimulus; a cycle-count reference model predicts outputs.
`timescale 1ns/1ps
module tb_piso_tx;

  localparam int unsigned W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  logic         clk = 1'b0;
  logic         clear;
  logic         din_valid;
  logic [W-1:0] din;
  logic [1:0]   ready, sout, stb, busy, done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  piso_tx #(.WIDTH(W), .DIV(1)) u_dut_d1 (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid), .din_ready(ready[0]),
    .sout(sout[0]), .bit_stb(stb[0]), .busy(busy[0]), .done(done[0])
  );

  piso_tx #(.WIDTH(W), .DIV(3)) u_dut_d3 (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid), .din_ready(ready[1]),
    .sout(sout[1]), .bit_stb(stb[1]), .busy(busy[1]), .done(done[1])
  );

  always #5 clk = ~clk;

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [NB-1:0] load_word(input logic [W-1:0] d);
`ifdef PISO_TX_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Reference: a word occupies NB*DIV cycles counted from its handshake edge.
  logic [NB-1:0] m_word [2];
  int unsigned   m_t [2];
  bit            m_act [2];
  int unsigned   m_done_cnt [2];
  int unsigned   obs_done_cnt [2];
  logic [NB-1:0] down [2];

  always @(posedge clk or posedge clear) begin
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        m_act[i] <= 1'b0;
      end else if (m_act[i]) begin
        if (m_t[i] + 1 == NB * div_of(i)) m_act[i] <= 1'b0;
        m_t[i] <= m_t[i] + 1;
      end else if (din_valid) begin
        m_act[i]  <= 1'b1;
        m_t[i]    <= 0;
        m_word[i] <= load_word(din);
      end
    end
  end

  // {din_ready, busy, sout, bit_stb, done}
  function automatic logic [4:0] expect_out(input int i);
    int unsigned k, ph, d;
    logic [4:0]  e;
    d = div_of(i);
    if (clear) return 5'b00000;
    if (!m_act[i]) return 5'b10000;
    k    = m_t[i] / d;
    ph   = m_t[i] % d;
    e[4] = 1'b0;
    e[3] = 1'b1;
    e[2] = m_word[i][k];
    e[1] = (ph == d - 1);
    e[0] = e[1] && (k == NB - 1);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input bit sample);
    for (int i = 0; i < 2; i++) begin
      logic [4:0] obs;
      logic [4:0] exp;
      obs = {ready[i], busy[i], sout[i], stb[i], done[i]};
      exp = expect_out(i);
      check($sformatf("outputs_div%0d", div_of(i)), 32'(obs), 32'(exp));
      if (sample) begin
        if (exp[0]) m_done_cnt[i]++;
        if (done[i]) obs_done_cnt[i]++;
        if (stb[i]) down[i] = {sout[i], down[i][NB-1:1]};
        if (done[i]) check($sformatf("downstream_div%0d", div_of(i)), 32'(down[i]), 32'(m_word[i]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all(1'b1);
  endtask

  initial begin
    clear     = 1'b1;
    din_valid = 1'b1;
    din       = 4'hF;
    repeat (3) step();

    clear = 1'b0; din = 4'b1011; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = 4'h0;
    repeat (16) step();

    din = 4'hA; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = 4'h5;
    repeat (16) step();

    din = 4'h5; din_valid = 1'b1;
    step();
    din = 4'h3;
    repeat (20) step();
    repeat (30) begin
      din = W'($urandom);
      step();
    end
    din_valid = 1'b0;
    repeat (16) step();

    din = 4'h6; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (7) step();
    clear = 1'b1;
    #1;
    check_all(1'b0);
    step();
    clear = 1'b0; din = 4'h9; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (16) step();

    repeat (2000) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 199) == 0);
      if (clear) begin
        #1;
        check_all(1'b0);
      end
      step();
    end
    clear = 1'b0; din_valid = 1'b0;
    repeat (20) step();

    for (int i = 0; i < 2; i++)
      check($sformatf("done_count_div%0d", div_of(i)), obs_done_cnt[i], m_done_cnt[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
